// File: rtl/value_to_ascii.sv
// value_to_ascii: converts a 10-bit value in tenths (0..1023) to three ASCII
// digits (tens, units, tenths) for the LCD driver, using a fixed-latency
// double-dabble binary-to-BCD conversion. Values above 999 show "999" and raise ovf.
module value_to_ascii #(
   parameter bit BLANK_LEAD = 1'b1
) (
   input  logic       CLK,
   input  logic       btnr,
   input  logic       start,
   input  logic [9:0] value,
   output logic       busy,
   output logic       done,
   output logic       ovf,
   output logic [7:0] d10,
   output logic [7:0] d1,
   output logic [7:0] d10ths,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        accept;
   logic [9:0]  sr_q;      // binary value being shifted out MSB first
   logic [13:0] bcd_q;     // {thousands[1:0], hundreds, tens, units}
   logic [11:0] low_adj;   // hundreds/tens/units after the add-3 step
   logic [3:0]  iter_q;

   assign busy      = (state_q != IDLE);
   assign state_dbg = state_q;

   // State register; btnr aborts any conversion immediately.
   always_ff @(posedge CLK or posedge btnr) begin
      if (btnr) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic: accept in IDLE, 10 shift cycles in CONV, one publish cycle in DONE.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = CONV;
            end
         end
         CONV: begin
            if (iter_q == 4'd9) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
   // The thousands field only ever reaches 1, so it never needs correcting.
   always_comb begin
      low_adj = bcd_q[11:0];
      for (int n = 0; n < 3; n++) begin
         if (bcd_q[4*n +: 4] >= 4'd5) low_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
   end

   // Conversion datapath: load on accept, then one correct-and-shift per CONV cycle.
   always_ff @(posedge CLK or posedge btnr) begin
      if (btnr) begin
         sr_q   <= '0;
         bcd_q  <= '0;
         iter_q <= '0;
      end else if (accept) begin
         sr_q   <= value;
         bcd_q  <= '0;
         iter_q <= '0;
      end else if (state_q == CONV) begin
         bcd_q  <= {bcd_q[12], low_adj, sr_q[9]};
         sr_q   <= {sr_q[8:0], 1'b0};
         iter_q <= iter_q + 4'd1;
      end
   end

   // Result registers: updated only in DONE, otherwise held; done is a one-cycle pulse.
   always_ff @(posedge CLK or posedge btnr) begin
      if (btnr) begin
         done   <= 1'b0;
         ovf    <= 1'b0;
         d10    <= 8'h30;
         d1     <= 8'h30;
         d10ths <= 8'h30;
      end else begin
         done <= 1'b0;
         if (state_q == DONE) begin
            done <= 1'b1;
            if (bcd_q[13:12] != 2'd0) begin
               ovf    <= 1'b1;
               d10    <= 8'h39;
               d1     <= 8'h39;
               d10ths <= 8'h39;
            end else begin
               ovf    <= 1'b0;
               d10    <= (BLANK_LEAD && bcd_q[11:8] == 4'd0) ? 8'h20
                                                              : 8'h30 + {4'h0, bcd_q[11:8]};
               d1     <= 8'h30 + {4'h0, bcd_q[7:4]};
               d10ths <= 8'h30 + {4'h0, bcd_q[3:0]};
            end
         end
      end
   end

endmodule

// File: tb/tb_value_to_ascii.sv
// Bench for value_to_ascii: two instances (leading blank on/off) share stimulus;
// expected digits come from a decimal arithmetic model and are queued at accept time,
// a negedge monitor pops and compares whenever done is seen.
module tb_value_to_ascii;

   logic       CLK;
   logic       btnr;
   logic       start;
   logic [9:0] value;

   logic       busy0, done0, ovf0;
   logic [7:0] d10_0, d1_0, d10ths_0;
   logic [1:0] st0;
   logic       busy1, done1, ovf1;
   logic [7:0] d10_1, d1_1, d10ths_1;
   logic [1:0] st1;

   logic [49:0] exp_q[$];   // {blank-lead result, no-blank result}
   int          t_q[$];     // cycle at which done is due
   logic [24:0] last0, last1;
   int          cyc;
   int          checks;
   int          errors;

   localparam logic [24:0] RST_OUT = {8'h30, 8'h30, 8'h30, 1'b0};

   value_to_ascii #(.BLANK_LEAD(1'b1)) dut0 (
      .CLK(CLK), .btnr(btnr), .start(start), .value(value),
      .busy(busy0), .done(done0), .ovf(ovf0),
      .d10(d10_0), .d1(d1_0), .d10ths(d10ths_0), .state_dbg(st0)
   );

   value_to_ascii #(.BLANK_LEAD(1'b0)) dut1 (
      .CLK(CLK), .btnr(btnr), .start(start), .value(value),
      .busy(busy1), .done(done1), .ovf(ovf1),
      .d10(d10_1), .d1(d1_1), .d10ths(d10ths_1), .state_dbg(st1)
   );

   // clock / cycle counter
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   initial cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference: decimal digits of v/10 with plain arithmetic.
   function automatic logic [24:0] model(input int v, input bit blank);
      int h, t, u;
      logic [7:0] a, b, c;
      if (v > 999) return {8'h39, 8'h39, 8'h39, 1'b1};
      h = v / 100;
      t = (v / 10) % 10;
      u = v % 10;
      a = (blank && h == 0) ? 8'h20 : 8'(8'h30 + h);
      b = 8'(8'h30 + t);
      c = 8'(8'h30 + u);
      return {a, b, c, 1'b0};
   endfunction

   // Called at the negedge right after the accepting edge.
   task automatic push_exp(input int v);
      exp_q.push_back({model(v, 1'b1), model(v, 1'b0)});
      t_q.push_back(cyc + 11);
   endtask

   // Driver: one start pulse; call shortly after a negedge with the DUT idle.
   // Returns at the negedge where done is expected.
   task automatic conv(input int v);
      int nb;
      value = 10'(v);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      push_exp(v);
      value = 10'($urandom_range(0, 1023));   // must not disturb the result
      nb = 0;
      repeat (11) begin
         nb += int'(busy0) + int'(busy1);
         @(negedge CLK);
      end
      chk("busy_cycles", 64'(nb), 64'd22);
      chk("busy_low_at_done", 64'({busy0, busy1}), 64'd0);
   endtask

   // Monitor / scoreboard
   initial begin
      last0 = RST_OUT;
      last1 = RST_OUT;
   end

   always @(negedge CLK) begin
      logic [49:0] e;
      int t;
      if (btnr) begin
         chk("rst_out0", 64'({d10_0, d1_0, d10ths_0, ovf0}), 64'(RST_OUT));
         chk("rst_out1", 64'({d10_1, d1_1, d10ths_1, ovf1}), 64'(RST_OUT));
         chk("rst_busy_done", 64'({busy0, done0, busy1, done1}), 64'd0);
         last0 = RST_OUT;
         last1 = RST_OUT;
      end else begin
         if (done0 || done1) begin
            if (exp_q.size() == 0) begin
               chk("spurious_done", 64'({done0, done1}), 64'd0);
            end else begin
               e = exp_q.pop_front();
               t = t_q.pop_front();
               chk("done_pair", 64'({done0, done1}), 64'd3);
               chk("latency", 64'(cyc), 64'(t));
               chk("out_blank", 64'({d10_0, d1_0, d10ths_0, ovf0}), 64'(e[49:25]));
               chk("out_noblank", 64'({d10_1, d1_1, d10ths_1, ovf1}), 64'(e[24:0]));
               last0 = e[49:25];
               last1 = e[24:0];
            end
         end else begin
            chk("hold0", 64'({d10_0, d1_0, d10ths_0, ovf0}), 64'(last0));
            chk("hold1", 64'({d10_1, d1_1, d10ths_1, ovf1}), 64'(last1));
         end
         chk("busy_and_done", 64'({busy0 & done0, busy1 & done1}), 64'd0);
      end
   end

   // Stimulus
   initial begin
      int dirs[5];
      checks = 0;
      errors = 0;
      btnr   = 1'b1;
      start  = 1'b0;
      value  = '0;
      repeat (3) @(negedge CLK);
      #2 btnr = 1'b0;

      // directed values: typical, leading blank, max in range, overflow
      dirs = '{123, 5, 999, 1000, 1023};
      foreach (dirs[i]) conv(dirs[i]);

      // starts during busy ignored, value change after accept ignored
      value = 10'd123;
      start = 1'b1;
      @(negedge CLK);               // after edge k
      start = 1'b0;
      push_exp(123);
      @(negedge CLK);  value = 10'd456;
      @(negedge CLK);  start = 1'b1; // covers edge k+3
      @(negedge CLK);  start = 1'b0;
      repeat (7) @(negedge CLK);
      start = 1'b1;                  // covers edge k+11 (DONE)
      @(negedge CLK);  start = 1'b0;
      repeat (3) @(negedge CLK);

      // reset in the middle of a conversion
      value = 10'd777;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (4) @(negedge CLK);
      #2 btnr = 1'b1;
      @(negedge CLK);
      #2 btnr = 1'b0;
      conv(777);

      // start held high: back-to-back every 12 cycles, value stepping 0..20
      start = 1'b1;
      for (int v = 0; v <= 20; v++) begin
         value = 10'(v);
         @(negedge CLK);
         push_exp(v);
         repeat (11) @(negedge CLK);
      end
      start = 1'b0;
      repeat (2) @(negedge CLK);

      // randomized values and idle gaps
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge CLK);
         conv(int'($urandom_range(0, 1023)));
      end

      repeat (5) @(negedge CLK);
      chk("pending_results", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
